// File: rtl/floo_vc_credit_tx.sv
// Transmit endpoint of a credit-based virtual-channel link.
// Accepts an upstream valid/ready flit stream tagged with a target VC and
// forwards each flit to the link one cycle later. A flit is only accepted
// while the downstream buffer of its VC has a free slot, tracked by one
// credit counter per VC that is replenished by returned credits.
module floo_vc_credit_tx #(
   parameter int unsigned NumVC        = 4,
   parameter int unsigned VCIdWidth    = 2,
   parameter int unsigned VCDepth      = 2,
   parameter int unsigned VCDepthWidth = $clog2(VCDepth + 1),
   parameter int unsigned FlitWidth    = 64,
   parameter bit          CreditBypass = 1'b0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [VCIdWidth-1:0]          vc_id_i,
   input  logic [FlitWidth-1:0]          data_i,
   output logic                          data_v_o,
   output logic [FlitWidth-1:0]          data_o,
   output logic [VCIdWidth-1:0]          vc_id_o,
   input  logic                          credit_v_i,
   input  logic [VCIdWidth-1:0]          credit_id_i,
   output logic [NumVC*VCDepthWidth-1:0] credit_cnt_o,
   output logic                          credit_err_o
);

   // NumVC widened by one bit so that ids of any VCIdWidth compare cleanly.
   localparam logic [VCIdWidth:0]      NumVCExt = (VCIdWidth + 1)'(NumVC);
   localparam logic [VCDepthWidth-1:0] FullCnt  = VCDepthWidth'(VCDepth);

   logic [VCDepthWidth-1:0] cnt_q [NumVC];
   logic [VCDepthWidth-1:0] cnt_d [NumVC];
   logic                    err_q, err_d;
   logic                    data_v_q, data_v_d;
   logic [FlitWidth-1:0]    data_q, data_d;
   logic [VCIdWidth-1:0]    vc_id_q, vc_id_d;

   logic [NumVC-1:0]        inc, dec, avail;
   logic                    credit_in_range;
   logic                    send;
   logic                    overflow;

   // Credit availability per VC, upstream handshake and per-VC inc/dec strobes.
   always_comb begin
      ready_o = 1'b0;
      inc     = '0;
      dec     = '0;
      avail   = '0;
      for (int unsigned v = 0; v < NumVC; v++) begin
         inc[v]   = credit_v_i && (credit_id_i == VCIdWidth'(v));
         avail[v] = (cnt_q[v] != '0) || (CreditBypass && inc[v]);
         // An id outside 0..NumVC-1 never matches, so ready_o stays low for it.
         if (vc_id_i == VCIdWidth'(v)) begin
            ready_o = avail[v];
         end
      end
      if (rst_i) begin
         ready_o = 1'b0;
      end
      send = valid_i && ready_o;
      for (int unsigned v = 0; v < NumVC; v++) begin
         dec[v] = send && (vc_id_i == VCIdWidth'(v));
      end
   end

   // Next credit counts and sticky protocol-error detection.
   always_comb begin
      overflow        = 1'b0;
      credit_in_range = ({1'b0, credit_id_i} < NumVCExt);
      for (int unsigned v = 0; v < NumVC; v++) begin
         cnt_d[v] = cnt_q[v];
         if (inc[v] && !dec[v]) begin
            if (cnt_q[v] < FullCnt) begin
               cnt_d[v] = cnt_q[v] + VCDepthWidth'(1);
            end else begin
               overflow = 1'b1;
            end
         end else if (dec[v] && !inc[v]) begin
            cnt_d[v] = cnt_q[v] - VCDepthWidth'(1);
         end
      end
      err_d = err_q || overflow || (credit_v_i && !credit_in_range);
   end

   // Link output stage: one-cycle pulse per accepted flit, payload held otherwise.
   always_comb begin
      data_v_d = send;
      data_d   = send ? data_i  : data_q;
      vc_id_d  = send ? vc_id_i : vc_id_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned v = 0; v < NumVC; v++) begin
            cnt_q[v] <= FullCnt;
         end
         err_q    <= 1'b0;
         data_v_q <= 1'b0;
         data_q   <= '0;
         vc_id_q  <= '0;
      end else begin
         for (int unsigned v = 0; v < NumVC; v++) begin
            cnt_q[v] <= cnt_d[v];
         end
         err_q    <= err_d;
         data_v_q <= data_v_d;
         data_q   <= data_d;
         vc_id_q  <= vc_id_d;
      end
   end

   // A counter at zero may only be spent when a same-cycle credit covers it.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int unsigned v = 0; v < NumVC; v++) begin
            assert (!(dec[v] && !inc[v] && (cnt_q[v] == '0)));
         end
      end
   end

   // Pack counters onto the status port, VC0 in the least significant bits.
   always_comb begin
      credit_cnt_o = '0;
      for (int unsigned v = 0; v < NumVC; v++) begin
         credit_cnt_o[v*VCDepthWidth +: VCDepthWidth] = cnt_q[v];
      end
   end

   assign data_v_o     = data_v_q;
   assign data_o       = data_q;
   assign vc_id_o      = vc_id_q;
   assign credit_err_o = err_q;

endmodule

// File: tb/tb_floo_vc_credit_tx.sv
// Scoreboard bench for floo_vc_credit_tx: a VC-credit reference model
// predicts ready_o, counters and the error flag; accepted flits are queued and
// a monitor matches them against link output pulses.
module tb_floo_vc_credit_tx;

   localparam int NVC = 4;
   localparam int DEP = 2;
   localparam int DW  = 2;
   localparam int FW  = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT: CreditBypass=0, 3-bit VC ids so out-of-range ids can be driven.
   logic          rst = 1'b1, valid = 1'b0, cv = 1'b0;
   logic [2:0]    vid = '0, cid = '0;
   logic [FW-1:0] din = '0;
   logic          ready_o, data_v_o, credit_err_o;
   logic [FW-1:0] data_o;
   logic [2:0]    vc_id_o;
   logic [NVC*DW-1:0] credit_cnt_o;

   floo_vc_credit_tx #(
      .NumVC(NVC), .VCIdWidth(3), .VCDepth(DEP), .VCDepthWidth(DW),
      .FlitWidth(FW), .CreditBypass(1'b0)
   ) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready_o),
      .vc_id_i(vid), .data_i(din), .data_v_o(data_v_o), .data_o(data_o),
      .vc_id_o(vc_id_o), .credit_v_i(cv), .credit_id_i(cid),
      .credit_cnt_o(credit_cnt_o), .credit_err_o(credit_err_o)
   );

   // Second DUT with the credit bypass enabled.
   logic          b_rst = 1'b1, b_valid = 1'b0, b_cv = 1'b0;
   logic [1:0]    b_vid = '0, b_cid = '0;
   logic [FW-1:0] b_din = '0;
   logic          b_ready, b_data_v, b_err;
   logic [FW-1:0] b_data;
   logic [1:0]    b_vc;
   logic [NVC*DW-1:0] b_cnt;

   floo_vc_credit_tx #(
      .NumVC(NVC), .VCIdWidth(2), .VCDepth(DEP), .VCDepthWidth(DW),
      .FlitWidth(FW), .CreditBypass(1'b1)
   ) dut_byp (
      .clk_i(clk), .rst_i(b_rst), .valid_i(b_valid), .ready_o(b_ready),
      .vc_id_i(b_vid), .data_i(b_din), .data_v_o(b_data_v), .data_o(b_data),
      .vc_id_o(b_vc), .credit_v_i(b_cv), .credit_id_i(b_cid),
      .credit_cnt_o(b_cnt), .credit_err_o(b_err)
   );

   typedef struct { logic [2:0] vc; logic [FW-1:0] d; } flit_t;
   typedef struct { int vc; int due; } credit_t;

   flit_t   exp_q [$];
   credit_t pend  [$];
   int      mcnt  [NVC];
   bit      merr;
   bit      mon_en = 1'b0;
   int      checks = 0;
   int      errors = 0;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // A flit may go out when reset is low, its VC exists and a slot is free.
   function automatic bit model_ready(input bit r, input int id);
      return !r && (id < NVC) && (mcnt[id] > 0);
   endfunction

   // One clock of stimulus on the main DUT plus the reference-model update.
   task automatic cycle(input bit r, input bit vl, input logic [2:0] id, input logic [FW-1:0] d,
                        input bit c, input logic [2:0] ci, output bit acc, output bit rdy);
      bit exp_r;
      @(negedge clk);
      rst = r; valid = vl; vid = id; din = d; cv = c; cid = ci;
      #1;
      exp_r = model_ready(r, int'(id));
      rdy   = ready_o;
      chk("ready_o", ready_o, exp_r);
      acc = vl && exp_r;
      if (acc) exp_q.push_back('{vc: id, d: d});
      @(posedge clk);
      #1;
      if (r) begin
         for (int v = 0; v < NVC; v++) mcnt[v] = DEP;
         merr = 1'b0;
      end else begin
         for (int v = 0; v < NVC; v++) begin
            bit sent, freed;
            sent  = acc && (int'(id) == v);
            freed = c && (int'(ci) == v);
            if (freed && !sent) begin
               if (mcnt[v] < DEP) mcnt[v]++;
               else merr = 1'b1;
            end else if (sent && !freed) begin
               mcnt[v]--;
            end
         end
         if (c && int'(ci) >= NVC) merr = 1'b1;
      end
   endtask

   // Monitor: pop one expected flit per link pulse, track counters and error flag.
   always @(negedge clk) begin
      if (mon_en) begin
         if (data_v_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_flit", 64'd1, 64'd0);
            end else begin
               flit_t e;
               e = exp_q.pop_front();
               chk("data_o", data_o, e.d);
               chk("vc_id_o", {61'd0, vc_id_o}, {61'd0, e.vc});
            end
         end
         for (int v = 0; v < NVC; v++) begin
            int got;
            got = int'(credit_cnt_o[v*DW +: DW]);
            chk("credit_cnt", 64'(got), 64'(mcnt[v]));
            if (got < 0 || got > DEP) chk("cnt_range", 64'(got), 64'(DEP));
         end
         chk("credit_err_o", credit_err_o, merr);
      end
   end

   task automatic bcycle(input bit r, input bit vl, input logic [1:0] id, input logic [FW-1:0] d,
                         input bit c, input logic [1:0] ci, output bit rdy);
      @(negedge clk);
      b_rst = r; b_valid = vl; b_vid = id; b_din = d; b_cv = c; b_cid = ci;
      #1;
      rdy = b_ready;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc, rdy;
      int now, sent, iter;

      // Reset state
      cycle(1, 0, 0, '0, 0, 0, acc, rdy);
      mon_en = 1'b1;
      chk("rst_cnt", credit_cnt_o, 8'hAA);
      chk("rst_data_v", data_v_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_vc", vc_id_o, 0);
      chk("rst_err", credit_err_o, 0);

      // Two flits to VC1 exhaust its credits; VC0 still flows
      cycle(0, 1, 1, 64'hA1, 0, 0, acc, rdy);
      chk("vc1_cnt_1", credit_cnt_o[3:2], 1);
      chk("first_pulse", data_v_o, 1);
      cycle(0, 1, 1, 64'hA2, 0, 0, acc, rdy);
      chk("vc1_cnt_0", credit_cnt_o[3:2], 0);
      cycle(0, 1, 1, 64'hA3, 0, 0, acc, rdy);
      chk("vc1_blocked", rdy, 0);
      cycle(0, 1, 0, 64'hB0, 0, 0, acc, rdy);
      chk("vc0_ok", rdy, 1);

      // No bypass: the returned credit is usable only the following cycle
      cycle(0, 1, 1, 64'hA3, 1, 1, acc, rdy);
      chk("nobyp_same", rdy, 0);
      chk("nobyp_cnt", credit_cnt_o[3:2], 1);
      cycle(0, 1, 1, 64'hA3, 0, 0, acc, rdy);
      chk("nobyp_next", rdy, 1);
      chk("nobyp_end", credit_cnt_o[3:2], 0);

      // Simultaneous send and credit on VC2
      cycle(0, 1, 2, 64'hC1, 0, 0, acc, rdy);
      cycle(0, 1, 2, 64'hC2, 1, 2, acc, rdy);
      chk("vc2_hold", credit_cnt_o[5:4], 1);
      chk("vc2_pulse", data_v_o, 1);
      chk("vc2_data", data_o, 64'hC2);

      // Out-of-range target VC is never accepted
      cycle(0, 1, 6, 64'hDD, 0, 0, acc, rdy);
      chk("vc6_ready", rdy, 0);
      cycle(0, 0, 0, '0, 0, 0, acc, rdy);
      chk("hold_data", data_o, 64'hC2);
      chk("idle_pulse", data_v_o, 0);

      // Credit overflow on a full VC3 is sticky
      cycle(0, 0, 0, '0, 1, 3, acc, rdy);
      chk("ovf_err", credit_err_o, 1);
      chk("ovf_cnt3", credit_cnt_o[7:6], 2);
      cycle(0, 0, 0, '0, 0, 0, acc, rdy);
      chk("ovf_sticky", credit_err_o, 1);

      // Credit for a non-existent VC
      cycle(1, 0, 0, '0, 0, 0, acc, rdy);
      chk("rst_clr_err", credit_err_o, 0);
      cycle(0, 0, 0, '0, 1, 5, acc, rdy);
      chk("badid_err", credit_err_o, 1);
      chk("badid_cnt", credit_cnt_o, 8'hAA);

      // Random streaming with delayed credit return
      cycle(1, 0, 0, '0, 0, 0, acc, rdy);
      now = 0; sent = 0; iter = 0;
      while (sent < 100 && iter < 5000) begin
         bit vl, c;
         int vc, ci, idx;
         logic [FW-1:0] d;
         vl = ($urandom_range(0, 3) != 0);
         vc = $urandom_range(0, NVC - 1);
         d  = {$urandom, $urandom};
         c = 1'b0; ci = 0; idx = -1;
         for (int k = 0; k < pend.size(); k++) begin
            if (idx < 0 && pend[k].due <= now) idx = k;
         end
         if (idx >= 0) begin
            c = 1'b1; ci = pend[idx].vc; pend.delete(idx);
         end
         cycle(0, vl, 3'(vc), d, c, 3'(ci), acc, rdy);
         if (acc) begin
            pend.push_back('{vc: vc, due: now + 1 + int'($urandom_range(0, 5))});
            sent++;
         end
         now++; iter++;
      end
      chk("stream_sent", 64'(sent), 64'd100);
      iter = 0;
      while (pend.size() > 0 && iter < 1000) begin
         credit_t cr;
         cr = pend.pop_front();
         cycle(0, 0, 0, '0, 1, 3'(cr.vc), acc, rdy);
         iter++;
      end
      cycle(0, 0, 0, '0, 0, 0, acc, rdy);
      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      chk("stream_cnt", credit_cnt_o, 8'hAA);
      chk("stream_err", credit_err_o, 0);

      // Reset mid-operation with VC0 empty, a flit in flight and one pending
      cycle(0, 0, 0, '0, 1, 7, acc, rdy);
      cycle(0, 1, 0, 64'hE1, 0, 0, acc, rdy);
      cycle(0, 1, 0, 64'hE2, 0, 0, acc, rdy);
      chk("pre_rst_cnt0", credit_cnt_o[1:0], 0);
      chk("pre_rst_err", credit_err_o, 1);
      cycle(1, 1, 0, 64'hE3, 0, 0, acc, rdy);
      chk("rst_ready", rdy, 0);
      chk("rst_drop_pulse", data_v_o, 0);
      chk("rst_cnt_mid", credit_cnt_o, 8'hAA);
      chk("rst_err_mid", credit_err_o, 0);
      cycle(0, 0, 0, '0, 0, 0, acc, rdy);
      chk("final_queue", 64'(exp_q.size()), 64'd0);

      // Bypass instance: credit returned in the same cycle is spent at once
      bcycle(1, 0, 0, '0, 0, 0, rdy);
      chk("byp_rst_cnt", b_cnt, 8'hAA);
      bcycle(0, 1, 1, 64'hF1, 0, 0, rdy);
      bcycle(0, 1, 1, 64'hF2, 0, 0, rdy);
      chk("byp_cnt0", b_cnt[3:2], 0);
      bcycle(0, 1, 1, 64'hF3, 0, 0, rdy);
      chk("byp_block", rdy, 0);
      chk("byp_no_pulse", b_data_v, 0);
      bcycle(0, 1, 1, 64'hF4, 1, 1, rdy);
      chk("byp_ready", rdy, 1);
      chk("byp_cnt_stay", b_cnt[3:2], 0);
      chk("byp_pulse", b_data_v, 1);
      chk("byp_data", b_data, 64'hF4);
      chk("byp_vc", b_vc, 1);
      chk("byp_err", b_err, 0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
